priority_arbiter4: RTL and testbench
====================================

PRIORITY_ARBITER4 -- requirements
Module: priority_arbiter4

Interface
REQ-001 Parameter MAX_HOLD, default 8, SHALL set the maximum consecutive grant cycles per requester; 0 = unlimited.
REQ-002 Parameter RR_MODE, default 0, SHALL select the policy: 0 = fixed priority, 1 = rotating priority.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be a synchronous, active-low reset.
REQ-005 REQ  input  4  SHALL carry the per-requester request lines; REQ[i] high means requester i wants the shared resource.
REQ-006 GNT  output  4  SHALL be a registered one-hot grant vector; it SHALL be all-zero when no grant is active.
REQ-007 GNT_ID  output  2  SHALL be the registered binary index of the granted requester, valid only while VALID=1.
REQ-008 VALID  output  1  SHALL be a registered flag, high exactly when GNT is non-zero.
REQ-009 PREEMPT  output  1  SHALL be a registered one-cycle pulse marking a forced release on timeout.

Function
REQ-010 The state machine SHALL have two states, IDLE and GRANT.
REQ-011 In IDLE with REQ=0000, the block SHALL stay in IDLE with GNT=0000, VALID=0 and GNT_ID held.
REQ-012 In IDLE with REQ non-zero, the block SHALL select a winner and enter GRANT at the next edge (1-cycle latency) with GNT, GNT_ID and VALID set.
REQ-013 Fixed mode SHALL grant the highest set index among REQ[3:0] (REQ[3] highest).
REQ-014 Rotating mode SHALL keep a 2-bit pointer PTR and search PTR, PTR-1, ... mod 4, granting the first set request.
REQ-015 After each grant to index i in rotating mode, PTR SHALL become (i-1) mod 4; in fixed mode PTR SHALL be unused.
REQ-016 Once the block enters GRANT, the hold counter SHALL be 1 and SHALL increment on every further cycle spent in GRANT.
REQ-017 In GRANT, if REQ[GNT_ID]=0, the block SHALL return to IDLE at the next edge with GNT=0000 and VALID=0 (normal release).
REQ-018 In GRANT, if MAX_HOLD>0, the hold counter equals MAX_HOLD and REQ[GNT_ID]=1, the block SHALL return to IDLE, clear GNT and VALID, and pulse PREEMPT for exactly that one cycle.
REQ-019 At least one idle cycle (VALID=0) SHALL separate any two grants.
REQ-020 Changes on REQ bits other than REQ[GNT_ID] during GRANT SHALL NOT affect the current grant.
REQ-021 If normal release and timeout conditions coincide, the release SHALL take precedence and PREEMPT SHALL stay 0.
REQ-022 The hold counter SHALL be ceil(log2(MAX_HOLD+1)) bits wide, minimum 1 bit.
REQ-023 When MAX_HOLD=0, the counter SHALL saturate and never cause a timeout.
REQ-024 GNT SHALL never have more than one bit set, and GNT[GNT_ID] SHALL equal VALID at all times.

Reset
REQ-025 With rst_n=0 at a rising edge, the outputs SHALL become GNT=0000, GNT_ID=00, VALID=0 and PREEMPT=0.
REQ-026 Reset SHALL also set state=IDLE, hold counter=0 and PTR=3, so that the first rotating arbitration matches fixed priority.
REQ-027 Reset asserted during GRANT SHALL abort the grant at that edge with no PREEMPT pulse.
REQ-028 Arbitration SHALL resume on the first edge with rst_n=1.

Verification
REQ-029 Fixed mode, REQ=0001 held: one cycle later GNT=0001, GNT_ID=00, VALID=1. After REQ drops: next cycle GNT=0000, VALID=0.
REQ-030 Fixed mode, REQ=0110 then 1100: first grant GNT=0100 (ID 10). After requester 2 drops with REQ=1100, one idle cycle follows, then GNT=1000 (ID 11).
REQ-031 Rotating mode, REQ=1111 held, MAX_HOLD=2: grants follow the sequence 3,2,1,0,3. Each lasts 2 cycles with a PREEMPT pulse and one idle cycle between grants.
REQ-032 Fixed mode, MAX_HOLD=8, REQ=1000 held 20 cycles: VALID is high 8 cycles, then PREEMPT=1 and VALID=0 for 1 cycle, then requester 3 is granted again.
REQ-033 rst_n=0 asserted during an active grant: at the next edge GNT=0000, VALID=0, PREEMPT=0. In rotating mode, the first grant after release to REQ=1111 goes to index 3.
REQ-034 MAX_HOLD=0, REQ=0010 held 300 cycles: GNT=0010 stays continuously and PREEMPT is never asserted.

Source files
------------

// File: rtl/priority_arbiter4.sv
// Four-requester arbiter with fixed or rotating priority and an optional hold limit.
// Grants are registered, one-hot, and always separated by at least one idle cycle.

module priority_arbiter4_lane #(
    parameter int IDX     = 0,
    parameter int RR_MODE = 0
) (
    input  logic       req,
    input  logic [1:0] ptr,
    output logic       cand,
    output logic [1:0] rank
);
    localparam logic [1:0] LIDX = 2'(IDX);

    // Rank 0 is searched first; rotating mode counts down from PTR modulo 4.
    always_comb begin
        cand = req;
        if (RR_MODE != 0) rank = ptr - LIDX;
        else              rank = 2'd3 - LIDX;
    end
endmodule

module priority_arbiter4 #(
    parameter int MAX_HOLD = 8,
    parameter int RR_MODE  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] REQ,
    output logic [3:0] GNT,
    output logic [1:0] GNT_ID,
    output logic       VALID,
    output logic       PREEMPT
);
    localparam int NUM_LANES = 4;
    localparam int HOLD_W    = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t                         state_q, state_d;
    logic [3:0]                     gnt_q, gnt_d;
    logic [1:0]                     id_q, id_d;
    logic                           valid_q, valid_d;
    logic                           pre_q, pre_d;
    logic [HOLD_W-1:0]              hold_q, hold_d;
    logic [1:0]                     ptr_q, ptr_d;

    logic [NUM_LANES-1:0]           cand;
    logic [NUM_LANES-1:0][1:0]      rank;
    logic [1:0]                     win;
    logic                           found;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        priority_arbiter4_lane #(
            .IDX     (i),
            .RR_MODE (RR_MODE)
        ) u_lane (
            .req  (REQ[i]),
            .ptr  (ptr_q),
            .cand (cand[i]),
            .rank (rank[i])
        );
    end

    // Lowest rank among active requesters wins; ranks are a permutation so ties cannot occur.
    always_comb begin
        win   = 2'd0;
        found = 1'b0;
        for (int r = 0; r < NUM_LANES; r++) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (!found && cand[i] && (rank[i] == 2'(r))) begin
                    win   = 2'(i);
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        valid_d = valid_q;
        pre_d   = 1'b0;
        hold_d  = hold_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                gnt_d   = 4'b0000;
                valid_d = 1'b0;
                if (found) begin
                    state_d = GRANT;
                    gnt_d   = 4'(4'b0001 << win);
                    id_d    = win;
                    valid_d = 1'b1;
                    hold_d  = HOLD_W'(1);
                    if (RR_MODE != 0) ptr_d = win - 2'd1;
                end
            end
            GRANT: begin
                // A requester dropping its line beats a simultaneous timeout.
                if (!REQ[id_q]) begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    valid_d = 1'b0;
                end else if ((MAX_HOLD != 0) && (hold_q == HOLD_MAX)) begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    valid_d = 1'b0;
                    pre_d   = 1'b1;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            id_q    <= 2'd0;
            valid_q <= 1'b0;
            pre_q   <= 1'b0;
            hold_q  <= '0;
            ptr_q   <= 2'd3;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            pre_q   <= pre_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
        end
    end

    assign GNT     = gnt_q;
    assign GNT_ID  = id_q;
    assign VALID   = valid_q;
    assign PREEMPT = pre_q;
endmodule

// File: tb/tb_priority_arbiter4.sv
// Directed bench: fixed (MAX_HOLD=8), rotating (MAX_HOLD=2) and unlimited-hold instances
// driven in sequence; outputs compared as {PREEMPT, VALID, GNT_ID, GNT}.

module tb_priority_arbiter4;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] req_fix, req_rr, req_inf;
    logic [3:0] gnt_fix, gnt_rr, gnt_inf;
    logic [1:0] id_fix, id_rr, id_inf;
    logic       vld_fix, vld_rr, vld_inf;
    logic       pre_fix, pre_rr, pre_inf;

    int checks = 0;
    int fails  = 0;

    priority_arbiter4 #(.MAX_HOLD(8), .RR_MODE(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .REQ(req_fix),
        .GNT(gnt_fix), .GNT_ID(id_fix), .VALID(vld_fix), .PREEMPT(pre_fix)
    );
    priority_arbiter4 #(.MAX_HOLD(2), .RR_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .REQ(req_rr),
        .GNT(gnt_rr), .GNT_ID(id_rr), .VALID(vld_rr), .PREEMPT(pre_rr)
    );
    priority_arbiter4 #(.MAX_HOLD(0), .RR_MODE(0)) u_inf (
        .clk(clk), .rst_n(rst_n), .REQ(req_inf),
        .GNT(gnt_inf), .GNT_ID(id_inf), .VALID(vld_inf), .PREEMPT(pre_inf)
    );

    wire [7:0] o_fix = {pre_fix, vld_fix, id_fix, gnt_fix};
    wire [7:0] o_rr  = {pre_rr,  vld_rr,  id_rr,  gnt_rr};
    wire [7:0] o_inf = {pre_inf, vld_inf, id_inf, gnt_inf};

    function automatic logic [7:0] ex(input logic pre, input logic vld,
                                      input logic [1:0] id, input logic [3:0] gnt);
        return {pre, vld, id, gnt};
    endfunction

    function automatic logic [7:0] granted(input logic [1:0] id);
        logic [3:0] oh;
        oh = 4'(4'b0001 << id);
        return {1'b0, 1'b1, id, oh};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] rr_seq [5];
        rr_seq = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};

        rst_n   = 1'b0;
        req_fix = 4'b0000;
        req_rr  = 4'b0000;
        req_inf = 4'b0000;
        tick();
        tick();
        chk("reset_fix", o_fix, 8'h00);
        chk("reset_rr",  o_rr,  8'h00);
        chk("reset_inf", o_inf, 8'h00);

        // single requester, 1-cycle latency, release
        rst_n   = 1'b1;
        req_fix = 4'b0001;
        tick(); chk("fix_req0_grant", o_fix, granted(2'd0));
        tick(); chk("fix_req0_hold",  o_fix, granted(2'd0));
        req_fix = 4'b0000;
        tick(); chk("fix_req0_release", o_fix, ex(1'b0, 1'b0, 2'd0, 4'b0000));
        tick(); chk("fix_idle_stays", o_fix, ex(1'b0, 1'b0, 2'd0, 4'b0000));

        // highest index wins; other REQ bits don't disturb the grant
        req_fix = 4'b0110;
        tick(); chk("fix_0110_grant2", o_fix, granted(2'd2));
        tick(); chk("fix_0110_hold",   o_fix, granted(2'd2));
        req_fix = 4'b1100;
        tick(); chk("fix_1100_no_steal", o_fix, granted(2'd2));
        req_fix = 4'b1000;
        tick(); chk("fix_req2_drop_idle", o_fix, ex(1'b0, 1'b0, 2'd2, 4'b0000));
        tick(); chk("fix_grant3", o_fix, granted(2'd3));
        req_fix = 4'b0000;
        tick(); chk("fix_grant3_release", o_fix, ex(1'b0, 1'b0, 2'd3, 4'b0000));

        // timeout after 8 grant cycles, then regrant
        req_fix = 4'b1000;
        for (int k = 0; k < 8; k++) begin
            tick(); chk("fix_hold8_valid", o_fix, granted(2'd3));
        end
        tick(); chk("fix_preempt", o_fix, ex(1'b1, 1'b0, 2'd3, 4'b0000));
        tick(); chk("fix_regrant3", o_fix, granted(2'd3));
        req_fix = 4'b0000;
        tick(); chk("fix_regrant_release", o_fix, ex(1'b0, 1'b0, 2'd3, 4'b0000));

        // release coinciding with timeout: no PREEMPT
        req_fix = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            tick(); chk("fix_req2_hold8", o_fix, granted(2'd2));
        end
        req_fix = 4'b0000;
        tick(); chk("fix_release_beats_timeout", o_fix, ex(1'b0, 1'b0, 2'd2, 4'b0000));
        tick(); chk("fix_after_release_idle", o_fix, ex(1'b0, 1'b0, 2'd2, 4'b0000));

        // rotating, MAX_HOLD=2, all requesting: 3,2,1,0,3
        req_rr = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick(); chk("rr_grant_c1", o_rr, granted(rr_seq[g]));
            tick(); chk("rr_grant_c2", o_rr, granted(rr_seq[g]));
            tick(); chk("rr_preempt",  o_rr, ex(1'b1, 1'b0, rr_seq[g], 4'b0000));
        end

        // reset at the timeout point aborts the grant without PREEMPT; PTR back to 3
        tick(); chk("rr_grant2_before_rst", o_rr, granted(2'd2));
        tick(); chk("rr_grant2_hold", o_rr, granted(2'd2));
        rst_n = 1'b0;
        tick(); chk("rr_reset_abort", o_rr, 8'h00);
        chk("fix_reset_again", o_fix, 8'h00);
        rst_n = 1'b1;
        tick(); chk("rr_after_reset_grant3", o_rr, granted(2'd3));
        req_rr = 4'b0000;
        tick(); chk("rr_release", o_rr, ex(1'b0, 1'b0, 2'd3, 4'b0000));

        // unlimited hold: continuous grant, never preempted
        req_inf = 4'b0010;
        for (int k = 0; k < 300; k++) begin
            tick(); chk("inf_hold_continuous", o_inf, granted(2'd1));
        end
        req_inf = 4'b0000;
        tick(); chk("inf_release", o_inf, ex(1'b0, 1'b0, 2'd1, 4'b0000));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
